// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO enqueue arbiters.
package fifo_arb_pkg;

   localparam int ARB_TAGW   = 2;
   localparam int ARB_DWIDTH = 13;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // One FIFO entry: requester tag in the top bits, payload below.
   typedef struct packed {
      logic [ARB_TAGW-1:0]   tag;
      logic [ARB_DWIDTH-1:0] payload;
   } tag_payload_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of mask, searching upward from ptr with wrap.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int TAGW = 2
) (
   input  logic [NREQ-1:0] mask,
   input  logic [TAGW-1:0] ptr,
   output logic [TAGW-1:0] gnt,
   output logic            have_gnt
);

   // Scan ptr, ptr+1, ... modulo NREQ; the first hit wins.
   always_comb begin
      logic [TAGW-1:0] idx;
      gnt      = '0;
      have_gnt = 1'b0;
      idx      = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = ptr + TAGW'(i);
         if (!have_gnt && mask[idx]) begin
            gnt      = idx;
            have_gnt = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter sharing one FIFO enqueue port between requesters,
// with bounded bursts per grant and a tag prepended to each entry.
module fifo_enq_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int TAGW   = ARB_TAGW,
  parameter int DWIDTH = ARB_DWIDTH,
  parameter int BURST  = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_enq__ENA,
  input  logic [NREQ*DWIDTH-1:0] req_enq_v,
  output logic [NREQ-1:0]        req_enq__RDY,
  output logic                   out_enq__ENA,
  output logic [TAGW+DWIDTH-1:0] out_enq_v,
  input  logic                   out_enq__RDY,
  output logic [TAGW-1:0]        owner,
  output logic                   locked,
  output logic                   err
);

  localparam int BCW = $clog2(BURST + 1);

  arb_state_e      st_q, st_d;
  logic [TAGW-1:0] ptr_q, ptr_d;
  logic [TAGW-1:0] owner_q, owner_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic            err_q, err_d;

  logic [TAGW-1:0] pick_gnt;
  logic            pick_have;
  logic [TAGW-1:0] gnt;
  logic            have_gnt;
  logic [NREQ-1:0] rdy;
  logic            fire;
  logic            proto_err;
  tag_payload_t    fwd;

  rr_pick #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) u_pick (
    .mask     (req_valid),
    .ptr      (ptr_q),
    .gnt      (pick_gnt),
    .have_gnt (pick_have)
  );

  // Outputs are gated by nRST so nothing leaks out while reset is held.
  always_comb begin
    if (st_q == LOCKED) begin
      gnt      = owner_q;
      have_gnt = req_valid[owner_q];
    end else begin
      gnt      = pick_gnt;
      have_gnt = pick_have;
    end

    rdy = '0;
    if (out_enq__RDY && have_gnt && nRST) begin
      rdy = NREQ'(1) << gnt;
    end

    fire = req_enq__ENA[gnt] & rdy[gnt];

    proto_err = (|(req_enq__ENA & ~rdy)) ||
                ((req_enq__ENA & (req_enq__ENA - NREQ'(1))) != '0);

    fwd = '0;
    if (fire) begin
      fwd.tag     = gnt;
      fwd.payload = req_enq_v[gnt*DWIDTH +: DWIDTH];
    end
  end

  always_comb begin
    logic [BCW-1:0] nb;
    st_d    = st_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q | proto_err;
    nb      = bcnt_q + BCW'(1);

    case (st_q)
      IDLE: begin
        if (fire) begin
          owner_d = gnt;
          bcnt_d  = BCW'(1);
          if (BURST == 1) begin
            ptr_d = gnt + TAGW'(1);
          end else begin
            st_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (fire) begin
          bcnt_d = nb;
          if (nb == BCW'(BURST)) begin
            st_d  = IDLE;
            ptr_d = owner_q + TAGW'(1);
          end
        end else if (!req_valid[owner_q]) begin
          st_d   = IDLE;
          ptr_d  = owner_q + TAGW'(1);
          bcnt_d = '0;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st_q    <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
    end
  end

  assign req_enq__RDY = rdy;
  assign out_enq__ENA = fire;
  assign out_enq_v    = fwd;
  assign owner        = owner_q;
  assign locked       = (st_q == LOCKED);
  assign err          = err_q;

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Directed bench for fifo_enq_arbiter with hand-computed expectations.
module tb_fifo_enq_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  valid;
  logic [3:0]  ena;
  logic [12:0] pl [0:3];
  logic [51:0] payv;
  logic [3:0]  rdy;
  logic        out_ena;
  logic [14:0] out_v;
  logic        out_rdy;
  logic [1:0]  owner;
  logic        locked;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  int seq [9] = '{2, 2, 2, 2, 0, 0, 0, 0, 2};

  assign payv = {pl[3], pl[2], pl[1], pl[0]};

  always #5 CLK = ~CLK;

  fifo_enq_arbiter #(
    .NREQ   (4),
    .TAGW   (2),
    .DWIDTH (13),
    .BURST  (4)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .req_valid    (valid),
    .req_enq__ENA (ena),
    .req_enq_v    (payv),
    .req_enq__RDY (rdy),
    .out_enq__ENA (out_ena),
    .out_enq_v    (out_v),
    .out_enq__RDY (out_rdy),
    .owner        (owner),
    .locked       (locked),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] exp_v(input int t, input logic [12:0] p);
    logic [1:0] tt;
    tt = 2'(t);
    return {17'd0, tt, p};
  endfunction

  initial begin
    nRST    = 1'b0;
    valid   = 4'b0000;
    ena     = 4'b0000;
    out_rdy = 1'b1;
    pl[0]   = 13'h00AA;
    pl[1]   = 13'h0155;
    pl[2]   = 13'h01F0;
    pl[3]   = 13'h0F0F;

    // Reset held: everything quiet even with a valid requester.
    #3 valid = 4'b0010;
    #1;
    check("rst_rdy", 32'(rdy), 32'h0);
    check("rst_ena", 32'(out_ena), 32'h0);
    check("rst_v", 32'(out_v), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    // Single requester 1.
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("single_rdy", 32'(rdy), 32'h2);
    ena = 4'b0010;
    #1;
    check("single_ena", 32'(out_ena), 32'h1);
    check("single_v", 32'(out_v), 32'h2155);
    tick();
    ena   = 4'b0000;
    valid = 4'b0000;
    #1;
    check("single_owner", 32'(owner), 32'h1);
    check("single_locked", 32'(locked), 32'h1);
    check("single_rdy_drop", 32'(rdy), 32'h0);
    tick();
    check("single_release", 32'(locked), 32'h0);

    // Bursts alternating between requesters 0 and 2 (search starts at 2).
    valid = 4'b0101;
    for (int k = 0; k < 9; k++) begin
      ena = 4'(1) << seq[k];
      #1;
      check($sformatf("burst_rdy_%0d", k), 32'(rdy), 32'(4'(1) << seq[k]));
      check($sformatf("burst_v_%0d", k), 32'(out_v), exp_v(seq[k], pl[seq[k]]));
      tick();
    end
    ena = 4'b0000;

    // Back-pressure while requester 2 holds with one enqueue done.
    out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_rdy_%0d", k), 32'(rdy), 32'h0);
      check($sformatf("bp_locked_%0d", k), 32'(locked), 32'h1);
      check($sformatf("bp_owner_%0d", k), 32'(owner), 32'h2);
      tick();
    end
    out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ena = 4'b0100;
      #1;
      check($sformatf("bp_resume_%0d", k), 32'(rdy), 32'h4);
      tick();
    end
    ena = 4'b0000;
    #1;
    check("bp_done_locked", 32'(locked), 32'h0);
    check("bp_done_rdy", 32'(rdy), 32'h1);

    // Early release: requester 3 enqueues twice then drops valid.
    valid = 4'b1001;
    #1;
    check("er_rdy3", 32'(rdy), 32'h8);
    ena = 4'b1000;
    #1;
    check("er_v", 32'(out_v), exp_v(3, pl[3]));
    tick();
    tick();
    ena   = 4'b0000;
    valid = 4'b0001;
    #1;
    check("er_hold_rdy", 32'(rdy), 32'h0);
    check("er_hold_locked", 32'(locked), 32'h1);
    tick();
    check("er_idle", 32'(locked), 32'h0);
    check("er_rdy0", 32'(rdy), 32'h1);
    check("er_owner_kept", 32'(owner), 32'h3);
    ena = 4'b0001;
    tick();
    ena = 4'b0000;
    #1;
    check("er_owner0", 32'(owner), 32'h0);
    check("er_locked0", 32'(locked), 32'h1);

    // Protocol error: strobe from requester 1 while 2 is granted.
    valid = 4'b0100;
    check("pe_err_clear", 32'(err), 32'h0);
    tick();
    check("pe_rdy2", 32'(rdy), 32'h4);
    ena = 4'b0010;
    #1;
    check("pe_no_fwd", 32'(out_ena), 32'h0);
    check("pe_no_v", 32'(out_v), 32'h0);
    tick();
    ena = 4'b0000;
    #1;
    check("pe_err_set", 32'(err), 32'h1);
    check("pe_no_state", 32'(locked), 32'h0);
    ena = 4'b0110;
    #1;
    check("pe_legal_fwd", 32'(out_ena), 32'h1);
    check("pe_legal_v", 32'(out_v), exp_v(2, pl[2]));
    tick();
    ena = 4'b0100;
    #1;
    check("pe_locked", 32'(locked), 32'h1);
    check("pe_owner", 32'(owner), 32'h2);
    check("pe_err_sticky", 32'(err), 32'h1);
    tick();

    // Asynchronous reset mid-burst.
    #1 nRST = 1'b0;
    #1;
    check("mr_rdy", 32'(rdy), 32'h0);
    check("mr_ena", 32'(out_ena), 32'h0);
    check("mr_v", 32'(out_v), 32'h0);
    check("mr_locked", 32'(locked), 32'h0);
    check("mr_owner", 32'(owner), 32'h0);
    check("mr_err", 32'(err), 32'h0);
    ena   = 4'b0000;
    valid = 4'b0110;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("mr_search0", 32'(rdy), 32'h2);
    ena = 4'b0010;
    #1;
    check("mr_v1", 32'(out_v), exp_v(1, pl[1]));
    tick();
    ena = 4'b0000;
    #1;
    check("mr_owner1", 32'(owner), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_enq_arbiter.md
# fifo_enq_arbiter

Round-robin arbiter that shares the enqueue port of a single 15-bit `Fifo1Base` between four requesters. Each winning enqueue is forwarded in the same cycle with a 2-bit requester tag prepended, so the consumer can demultiplexes by tag. A granted requester may hold the port for a short burst of enqueues. The block sits between the requester modules and the `in$enq` port of the shared `Fifo1Base__PARAM__width__15` instance.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; a power of two.
- `TAGW`, 2: tag width; equals log2(`NREQ`).
- `DWIDTH`, 13: requester payload width; `TAGW`+`DWIDTH` = 15, the FIFO width.
- `BURST`, 4: maximum consecutive enqueues per grant; at least 1.

Ports:
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `nRST`  in  1  reset, asynchronous assert, active-low.
- `req$valid`  in  NREQ  bit i set means requester i has data pending.
- `req$enq__ENA`  in  NREQ  enqueue strobe; bit i is legal only while `req$enq__RDY`[i] is high.
- `req$enq$v`  in  NREQ*DWIDTH  payloads; requester i occupies bits [i*DWIDTH +: DWIDTH].
- `req$enq__RDY`  out  NREQ  one-hot or zero: requester i may enqueue this cycle.
- `out$enq__ENA`  out  1  to FIFO `in$enq__ENA`.
- `out$enq$v`  out  15  to FIFO `in$enq$v`; the value is {tag, payload}.
- `out$enq__RDY`  in  1  from FIFO `in$enq__RDY`.
- `owner`  out  TAGW  current or most recent grant holder.
- `locked`  out  1  high while in LOCKED.
- `err`  out  1  sticky protocol-error flag.

## Operation
- State: `st` ∈ {IDLE, LOCKED}; `ptr` (TAGW), the round-robin search start; `owner` (TAGW); `bcnt` (0..BURST); `err`.
- Reset: `st`=IDLE, `ptr`=0, `owner`=0, `bcnt`=0, `err`=0. While reset is asserted: all RDY=0, `out$enq__ENA`=0, `out$enq$v`=0, `locked`=0.
- Grant, combinational:
  - In LOCKED, `gnt`=`owner`, valid when `req$valid[owner]`=1.
  - In IDLE, `gnt` is the first i with `req$valid`[i]=1, searching `ptr`, `ptr`+1, … modulo NREQ.
  - `have_gnt` = 0 when no requester is valid.
- `req$enq__RDY`[i] = `out$enq__RDY` & `have_gnt` & (`gnt`==i).
- Forwarding is pure combinational:
  - `fire` = `req$enq__ENA`[gnt] & `req$enq__RDY`[gnt].
  - `out$enq__ENA` = `fire`.
  - `out$enq$v` = {gnt, payload[gnt]} when `fire`, else 0.
- Transitions on the clock edge:
  - IDLE & `fire`:
    - `owner`←`gnt`, `bcnt`←1.
    - If BURST=1: stay IDLE, `ptr`←`gnt`+1.
    - Otherwise: go to LOCKED.
  - LOCKED & `fire`: `bcnt`←`bcnt`+1. If the new `bcnt` equals BURST: go to IDLE, `ptr`←`owner`+1 (wraps modulo NREQ).
  - LOCKED & `req$valid[owner]`=0 with no fire: go to IDLE, `ptr`←`owner`+1, `bcnt`←0.
  - LOCKED & valid & !fire (FIFO full or requester idling): hold. No timeout; the FIFO back-pressure is the only stall.
- Protocol error: any ENA bit without its RDY, or more than one ENA bit set.
  - Sets `err` sticky until reset.
  - The offending strobes are ignored: no forward, no state change. A legal `fire` in the same cycle still proceeds.
- `locked` = (`st`==LOCKED).

## Timing
- Enqueue latency is 0 cycles: requester ENA appears on `out$enq__ENA` in the same cycle. The FIFO presents the data on `out$first` one cycle later.
- A grant decision made at edge N is visible in RDY after edge N. Ownership never changes mid-cycle.
- `out$enq__RDY` falling drops all RDY in the same cycle, with no state change.
- A `req$valid` change affects grant selection in the same cycle when in IDLE, and is sampled at the edge when in LOCKED.
- When `nRST` asserts mid-burst, all state clears asynchronously. The first grant after release searches from 0.

## Structure
- Shared package `fifo_arb_pkg`:
  - state enum {IDLE, LOCKED};
  - the `TAGW`/`DWIDTH` split constant;
  - a `tag_payload_t` packed struct {tag, payload} sized to 15 bits.
- Sub-module `rr_pick`: combinational first-set-bit-from-pointer (NREQ-bit mask, TAGW ptr → gnt, have_gnt). It is reused by other arbiters.
- The FIFO instance stays outside this block; the parent wires `out$enq*` to it.

## Test plan
- Reset then single requester:
  - Stimulus: `req$valid`=0b0010, payload1=0x155, FIFO always ready.
  - Required: RDY=0b0010; on ENA, `out$enq$v`=0x2155 ({01,0x155}); `owner`=1; `locked`=1 after the first edge.
- Burst limit, BURST=4:
  - Stimulus: requesters 0 and 2 valid continuously, FIFO ready every cycle.
  - Required: tags 0,0,0,0,2,2,2,2,0… with `ptr` wrapping.
- Early release:
  - Stimulus: requester 3 owns, enqueues twice, drops valid; requester 0 valid.
  - Required: next grant goes to 0 (`ptr` wrapped 3→0); `bcnt` reset.
- Back-pressure:
  - Stimulus: `out$enq__RDY`=0 for 5 cycles during LOCKED.
  - Required: all RDY=0; `owner`, `bcnt` and `st` unchanged; the burst resumes at the correct count.
- Protocol error:
  - Stimulus: ENA on requester 1 while only requester 2 is granted.
  - Required: no forward, `err`=1 and stays set until `nRST`.
- Reset mid-burst:
  - Stimulus: assert `nRST` asynchronously with `bcnt`=2.
  - Required: outputs are 0 immediately; after release, grant searches from 0.
